switch_box_cfg: RTL and testbench

- Parametrised, configurable FPGA-fabric switch box: WIDTH tracks per side (N/E/S/W), each output track driven from one of the other three sides' same-index track, or left undriven.
- Configuration enters through a serial scan chain into a shadow register. An explicit commit copies it into the active register, so the routing never glitches during reconfiguration.
- Sits in the routing fabric between logic tiles. cfg_in/cfg_out daisy-chain from tile to tile.

---
 rtl/switch_box_cfg.sv | 132 +++++++++++++
 tb/tb_switch_box_cfg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_box_cfg.sv
// rtl/switch_box_cfg.sv - scan-configured four-sided routing switch box
// A shadow scan chain feeds the active routing config only on a legal commit.
module switch_box_cfg #(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_in,
    output logic             cfg_out,
    input  logic             cfg_commit,
    output logic             cfg_loaded,
    output logic             cfg_err,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] e_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] w_in,
    output logic [WIDTH-1:0] n_out,
    output logic [WIDTH-1:0] e_out,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] w_out,
    output logic [WIDTH-1:0] n_oe,
    output logic [WIDTH-1:0] e_oe,
    output logic [WIDTH-1:0] s_oe,
    output logic [WIDTH-1:0] w_oe
);
    localparam int CFG_BITS = 8 * WIDTH;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                shift_req, commit_req, clash;

    assign clash      = cfg_en & cfg_commit;
    assign shift_req  = cfg_en & ~cfg_commit;
    assign commit_req = cfg_commit & ~cfg_en;
    assign cfg_loaded = (count_q == CNT_FULL);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clash) begin
            err_d = 1'b1;
        end else if (shift_req) begin
            // keeps shifting after saturation so the chain still feeds downstream tiles
            shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
            if (!cfg_loaded) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (commit_req) begin
            if (cfg_loaded) begin
                active_d = shadow_q;
                count_d  = '0;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign cfg_out = shadow_q[0];
    assign cfg_err = err_q;

    // side index 0=N 1=E 2=S 3=W; source side is (self + sel) mod 4
    logic [3:0][WIDTH-1:0] side_in;
    logic [3:0][WIDTH-1:0] route_out, route_oe;
    logic [3:0][WIDTH-1:0] drv_out, drv_oe;

    assign side_in = {w_in, s_in, e_in, n_in};

    always_comb begin
        route_out = '0;
        route_oe  = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < WIDTH; t++) begin
                if (active_q[8*t+2*s +: 2] != 2'd0) begin
                    route_oe[s][t]  = 1'b1;
                    route_out[s][t] = side_in[2'(s) + active_q[8*t+2*s +: 2]][t];
                end
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [3:0][WIDTH-1:0] out_q, oe_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                    oe_q  <= '0;
                end else begin
                    out_q <= route_out;
                    oe_q  <= route_oe;
                end
            end
            assign drv_out = out_q;
            assign drv_oe  = oe_q;
        end else begin : g_comb
            assign drv_out = route_out;
            assign drv_oe  = route_oe;
        end
    endgenerate

    assign n_out = drv_out[0];
    assign e_out = drv_out[1];
    assign s_out = drv_out[2];
    assign w_out = drv_out[3];
    assign n_oe  = drv_oe[0];
    assign e_oe  = drv_oe[1];
    assign s_oe  = drv_oe[2];
    assign w_oe  = drv_oe[3];
endmodule

// File: tb/tb_switch_box_cfg.sv
// tb/tb_switch_box_cfg.sv - bench for switch_box_cfg, combinational and registered builds
module tb_switch_box_cfg;
    localparam int W = 4;

    typedef struct {
        logic [31:0] cfg;
        logic [15:0] ins;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cfg_en, cfg_commit, cfg_in;
    logic [W-1:0] n_in, e_in, s_in, w_in;
    logic         cfg_out0, cfg_loaded0, cfg_err0, cfg_out1, cfg_loaded1, cfg_err1;
    logic [W-1:0] n_out0, e_out0, s_out0, w_out0, n_oe0, e_oe0, s_oe0, w_oe0;
    logic [W-1:0] n_out1, e_out1, s_out1, w_out1, n_oe1, e_oe1, s_oe1, w_oe1;
    logic [31:0]  v0, v1;
    logic [2:0]   st0, st1;

    assign v0  = {n_out0, e_out0, s_out0, w_out0, n_oe0, e_oe0, s_oe0, w_oe0};
    assign v1  = {n_out1, e_out1, s_out1, w_out1, n_oe1, e_oe1, s_oe1, w_oe1};
    assign st0 = {cfg_out0, cfg_loaded0, cfg_err0};
    assign st1 = {cfg_out1, cfg_loaded1, cfg_err1};

    switch_box_cfg #(.WIDTH(W), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out0),
        .cfg_commit(cfg_commit), .cfg_loaded(cfg_loaded0), .cfg_err(cfg_err0),
        .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
        .n_out(n_out0), .e_out(e_out0), .s_out(s_out0), .w_out(w_out0),
        .n_oe(n_oe0), .e_oe(e_oe0), .s_oe(s_oe0), .w_oe(w_oe0)
    );

    switch_box_cfg #(.WIDTH(W), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out1),
        .cfg_commit(cfg_commit), .cfg_loaded(cfg_loaded1), .cfg_err(cfg_err1),
        .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
        .n_out(n_out1), .e_out(e_out1), .s_out(s_out1), .w_out(w_out1),
        .n_oe(n_oe1), .e_oe(e_oe1), .s_oe(s_oe1), .w_oe(w_oe1)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_active = '0;
    int          m_count = 0;
    logic        m_err = 1'b0;
    logic [31:0] sb[$];
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference routing written per side from the select tables
    function automatic logic [31:0] route(input logic [31:0] cfg, input logic [3:0] n,
                                          input logic [3:0] e, input logic [3:0] s,
                                          input logic [3:0] w);
        logic [3:0] no, eo, so, wo, noe, eoe, soe, woe;
        logic [1:0] sel;
        {no, eo, so, wo, noe, eoe, soe, woe} = '0;
        for (int t = 0; t < 4; t++) begin
            sel = cfg[8*t +: 2];
            noe[t] = (sel != 2'd0);
            case (sel) 2'd1: no[t] = e[t]; 2'd2: no[t] = s[t]; 2'd3: no[t] = w[t]; default: ; endcase
            sel = cfg[8*t+2 +: 2];
            eoe[t] = (sel != 2'd0);
            case (sel) 2'd1: eo[t] = s[t]; 2'd2: eo[t] = w[t]; 2'd3: eo[t] = n[t]; default: ; endcase
            sel = cfg[8*t+4 +: 2];
            soe[t] = (sel != 2'd0);
            case (sel) 2'd1: so[t] = w[t]; 2'd2: so[t] = n[t]; 2'd3: so[t] = e[t]; default: ; endcase
            sel = cfg[8*t+6 +: 2];
            woe[t] = (sel != 2'd0);
            case (sel) 2'd1: wo[t] = n[t]; 2'd2: wo[t] = e[t]; 2'd3: wo[t] = s[t]; default: ; endcase
        end
        return {no, eo, so, wo, noe, eoe, soe, woe};
    endfunction

    task automatic model_edge();
        if (cfg_en && cfg_commit) begin
            m_err = 1'b1;
        end else if (cfg_en) begin
            m_shadow = {cfg_in, m_shadow[31:1]};
            if (m_count < 32) m_count++;
        end else if (cfg_commit) begin
            if (m_count == 32) begin
                m_active = m_shadow;
                m_count  = 0;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] e;
        #1;
        e = route(m_active, n_in, e_in, s_in, w_in);
        chk("comb_route", v0, e);
        sb.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
        if (sb.size() > 0) chk("reg_lag_route", v1, sb.pop_front());
        chk("status0", {29'b0, st0}, {29'b0, m_shadow[0], (m_count == 32), m_err});
        chk("status1", {29'b0, st1}, {29'b0, m_shadow[0], (m_count == 32), m_err});
    endtask

    task automatic set_ins(input logic [15:0] v);
        {n_in, e_in, s_in, w_in} = v;
    endtask

    task automatic rnd_ins();
        {n_in, e_in, s_in, w_in} = 16'($urandom);
    endtask

    task automatic shift(input logic b);
        cfg_en = 1'b1; cfg_commit = 1'b0; cfg_in = b;
        cycle();
        cfg_en = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1; cfg_en = 1'b0;
        cycle();
        cfg_commit = 1'b0;
    endtask

    task automatic load(input logic [31:0] c);
        for (int i = 0; i < 32; i++) shift(c[i]);
    endtask

    initial begin
        logic [39:0] pat;
        logic [31:0] rc;
        tbl[0] = '{32'h0000_0039, 16'h0100, 32'h1010_1110};
        tbl[1] = '{32'h5555_5555, 16'hA3C5, 32'h3C5A_FFFF};
        tbl[2] = '{32'hAAAA_AAAA, 16'hA3C5, 32'hC5A3_FFFF};
        tbl[3] = '{32'hFFFF_FFFF, 16'hA3C5, 32'h5A3C_FFFF};
        tbl[4] = '{32'hE400_0000, 16'h8080, 32'h0888_0888};

        rst = 1'b1; cfg_en = 1'b0; cfg_commit = 1'b0; cfg_in = 1'b0;
        rnd_ins();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_out0", v0, 32'h0);
        chk("reset_out1", v1, 32'h0);
        chk("reset_stat0", {29'b0, st0}, 32'h0);
        chk("reset_stat1", {29'b0, st1}, 32'h0);
        rst = 1'b0;

        // full load: routing stays off while shifting, loaded only after bit 32
        set_ins(16'h0100);
        for (int i = 0; i < 32; i++) begin
            shift(tbl[0].cfg[i]);
            chk("load_off", v0, 32'h0);
            if (i == 30) chk("loaded_31", {31'b0, cfg_loaded0}, 32'd0);
        end
        chk("loaded_32", {31'b0, cfg_loaded0}, 32'd1);
        commit();
        #1;
        chk("first_commit", v0, 32'h1010_1110);
        chk("first_commit_err", {31'b0, cfg_err0}, 32'd0);

        for (int k = 0; k < 5; k++) begin
            set_ins(tbl[k].ins);
            load(tbl[k].cfg);
            commit();
            #1;
            chk("table_comb", v0, tbl[k].exp);
            cycle();
            chk("table_reg", v1, tbl[k].exp);
        end

        // early commit refused, then accepted one shift later
        for (int i = 0; i < 31; i++) shift(tbl[1].cfg[i]);
        commit();
        set_ins(tbl[4].ins);
        #1;
        chk("early_err", {31'b0, cfg_err0}, 32'd1);
        chk("early_keep", v0, tbl[4].exp);
        shift(tbl[1].cfg[31]);
        commit();
        set_ins(tbl[1].ins);
        #1;
        chk("late_err_clr", {31'b0, cfg_err0}, 32'd0);
        chk("late_active", v0, tbl[1].exp);

        for (int i = 0; i < 32; i++) begin
            shift(tbl[2].cfg[i]);
            chk("shift_live_hold", v0, tbl[1].exp);
        end
        cfg_en = 1'b1; cfg_commit = 1'b1; cfg_in = ~tbl[2].cfg[0];
        cycle();
        cfg_en = 1'b0; cfg_commit = 1'b0;
        chk("both_loaded", {31'b0, cfg_loaded0}, 32'd1);
        chk("both_err", {31'b0, cfg_err0}, 32'd1);
        chk("both_keep", v0, tbl[1].exp);
        chk("both_noshift", {31'b0, cfg_out0}, {31'b0, tbl[2].cfg[0]});
        commit();
        #1;
        chk("after_both", v0, tbl[2].exp);
        chk("after_both_err", {31'b0, cfg_err0}, 32'd0);

        // daisy chain: first bits reappear on cfg_out once the chain is full
        pat = {8'($urandom), $urandom};
        for (int k = 1; k <= 40; k++) begin
            shift(pat[k-1]);
            if (k >= 32) chk("chain_out", {31'b0, cfg_out0}, {31'b0, pat[k-32]});
        end
        chk("chain_loaded", {31'b0, cfg_loaded0}, 32'd1);

        for (int k = 0; k < 200; k++) begin
            rc = $urandom;
            for (int i = 0; i < 32; i++) begin
                rnd_ins();
                shift(rc[i]);
            end
            rnd_ins();
            commit();
            for (int j = 0; j < 3; j++) begin
                rnd_ins();
                cycle();
            end
        end

        // asynchronous reset in the middle of a shift
        for (int i = 0; i < 10; i++) shift(1'b1);
        cfg_en = 1'b1;
        rst = 1'b1;
        #2;
        chk("midrst_out0", v0, 32'h0);
        chk("midrst_out1", v1, 32'h0);
        chk("midrst_stat0", {29'b0, st0}, 32'h0);
        m_shadow = '0; m_active = '0; m_count = 0; m_err = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0; cfg_en = 1'b0;
        for (int i = 0; i < 31; i++) shift(1'b0);
        chk("midrst_count31", {31'b0, cfg_loaded0}, 32'd0);
        shift(1'b0);
        chk("midrst_count32", {31'b0, cfg_loaded0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
